psum_accumulator: RTL and testbench



---
 rtl/psum_accumulator.sv | 122 ++++++++++++
 tb/tb_psum_accumulator.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator: sums a programmable number of W-bit two's-complement terms
// and presents each finished group on a valid/ready port with a sticky overflow flag.
module psum_accumulator #(
  parameter int W     = 16,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic signed [W-1:0] acc;
  logic signed [W-1:0] term;
  logic signed [W-1:0] sum;
  logic                ovf;
  logic                beat_ovf;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    len_q;
  logic [CNT_W-1:0]    len_eff;
  logic [CNT_W:0]      cnt_inc;
  logic                accept;
  logic                take;

  // Wrapping add, identical to the upstream adder: no saturation, carry discarded.
  function automatic logic signed [W-1:0] wrap_add(input logic signed [W-1:0] a,
                                                    input logic signed [W-1:0] b);
    logic signed [W:0] full;
    full = {a[W-1], a} + {b[W-1], b};
    return full[W-1:0];
  endfunction

  function automatic logic add_ovf(input logic signed [W-1:0] a,
                                   input logic signed [W-1:0] b,
                                   input logic signed [W-1:0] s);
    return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  always_comb begin
    term     = signed'(in_data);
    sum      = wrap_add(acc, term);
    beat_ovf = add_ovf(acc, term, sum);
    len_eff  = (len == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : len;
    cnt_inc  = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
  end

  // Handshakes are decoded from state only, so in_valid never reaches in_ready
  // and out_ready never reaches out_valid.
  assign accept = in_valid & (state != HOLD);
  assign take   = out_ready & (state == HOLD);

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (len_eff == {{(CNT_W-1){1'b0}}, 1'b1}) ? HOLD : ACC;
      ACC:  if (accept && (cnt_inc == {1'b0, len_q})) state_nxt = HOLD;
      HOLD: if (take) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_ovf   = 1'b0;
    case (state)
      IDLE, ACC: in_ready = ~RST;
      HOLD: begin
        out_valid = 1'b1;
        out_data  = acc;
        out_ovf   = ovf;
      end
      default: ;
    endcase
  end

  // Sum, overflow, beat count and latched group length; reset discards any partial sum.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc   <= '0;
      ovf   <= 1'b0;
      cnt   <= '0;
      len_q <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          acc   <= term;
          ovf   <= 1'b0;
          cnt   <= {{(CNT_W-1){1'b0}}, 1'b1};
          len_q <= len_eff;
        end
        ACC: if (accept) begin
          acc <= sum;
          ovf <= ovf | beat_ovf;
          cnt <= cnt_inc[CNT_W-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: vector table, directed corner sequences, and randomized
// groups checked against an integer-arithmetic reference model.
module tb_psum_accumulator;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_ovf;

  int total = 0;
  int bad   = 0;

  psum_accumulator #(.W(16), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .len(len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0]  len;
    int          n;
    logic [15:0] d [4];
    int          gap;
    logic [15:0] exp_d;
    logic        exp_o;
  } vec_t;

  vec_t vt [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Present one term and return at the falling edge after it has been accepted.
  task automatic beat(input logic [15:0] d);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge CLK);
      t++;
    end
    if (!in_ready) check("beat_timeout", 0, 1);
    @(negedge CLK);
    in_valid = 1'b0;
  endtask

  // len is scrambled after the first beat: the group must keep its latched length.
  task automatic run_group(input logic [7:0] l, input logic [15:0] q[$], input int maxgap);
    len = l;
    for (int i = 0; i < q.size(); i++) begin
      if (i > 0) repeat ($urandom_range(0, maxgap)) @(negedge CLK);
      beat(q[i]);
      if (i == 0) len = 8'($urandom);
    end
  endtask

  task automatic result(input string name, input logic [15:0] ed, input logic eo,
                        input bit rand_ready);
    int  t;
    bit  r;
    check({name, "_latency"}, out_valid, 1);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge CLK);
      t++;
    end
    check({name, "_data"}, out_data, ed);
    check({name, "_ovf"}, out_ovf, eo);
    check({name, "_in_ready_low"}, in_ready, 0);
    if (!rand_ready) begin
      out_ready = 1'b1;
      @(negedge CLK);
      check({name, "_valid_one_cycle"}, out_valid, 0);
    end else begin
      t = 0;
      do begin
        r = (t > 10) ? 1'b1 : 1'($urandom);
        out_ready = r;
        @(negedge CLK);
        if (!r) check({name, "_hold_data"}, out_data, ed);
        t++;
      end while (!r);
      check({name, "_taken"}, out_valid, 0);
      out_ready = 1'b1;
    end
  endtask

  // Reference: true integer sum tracked per beat, wrapped to 16 bits,
  // overflow whenever the exact pairwise sum leaves the signed 16-bit range.
  function automatic void model(input logic [15:0] q[$], output logic [15:0] ed, output logic eo);
    int s;
    int t;
    logic signed [15:0] w;
    w  = q[0];
    s  = w;
    eo = 1'b0;
    for (int i = 1; i < q.size(); i++) begin
      w = q[i];
      t = s + int'(w);
      if (t > 32767 || t < -32768) eo = 1'b1;
      w = t[15:0];
      s = w;
    end
    ed = s[15:0];
  endfunction

  logic [15:0] q[$];
  logic [15:0] ed;
  logic        eo;

  initial begin
    vt[0] = '{8'd4, 4, '{16'h0001, 16'h0002, 16'h0003, 16'h0004}, 0, 16'h000A, 1'b0};
    vt[1] = '{8'd3, 3, '{16'h0005, 16'hFFFD, 16'hFFF9, 16'h0000}, 2, 16'hFFFB, 1'b0};
    vt[2] = '{8'd2, 2, '{16'h7FFF, 16'h0001, 16'h0000, 16'h0000}, 0, 16'h8000, 1'b1};
    vt[3] = '{8'd2, 2, '{16'h0001, 16'h0001, 16'h0000, 16'h0000}, 0, 16'h0002, 1'b0};
    vt[4] = '{8'd0, 1, '{16'h1234, 16'h0000, 16'h0000, 16'h0000}, 0, 16'h1234, 1'b0};
    vt[5] = '{8'd1, 1, '{16'h1234, 16'h0000, 16'h0000, 16'h0000}, 0, 16'h1234, 1'b0};
    vt[6] = '{8'd2, 2, '{16'h8000, 16'hFFFF, 16'h0000, 16'h0000}, 0, 16'h7FFF, 1'b1};
    vt[7] = '{8'd3, 3, '{16'h7FFF, 16'h0001, 16'h0001, 16'h0000}, 0, 16'h8001, 1'b1};

    RST = 1'b1; len = 8'd0; in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b1;
    repeat (3) @(negedge CLK);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ovf", out_ovf, 0);
    RST = 1'b0;
    #1;
    check("rst_release_in_ready", in_ready, 1);
    @(negedge CLK);

    for (int v = 0; v < 8; v++) begin
      q.delete();
      for (int i = 0; i < vt[v].n; i++) q.push_back(vt[v].d[i]);
      run_group(vt[v].len, q, vt[v].gap);
      result($sformatf("vec%0d", v), vt[v].exp_d, vt[v].exp_o, 1'b0);
    end

    // Backpressure: result held for 5 cycles while in_valid stays high.
    out_ready = 1'b0;
    len = 8'd2;
    beat(16'h0010);
    beat(16'h0020);
    in_valid = 1'b1;
    in_data  = 16'h0099;
    len      = 8'd1;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      check("bp_data", out_data, 16'h0030);
      @(negedge CLK);
    end
    out_ready = 1'b1;
    @(negedge CLK);
    check("bp_taken", out_valid, 0);
    check("bp_idle_ready", in_ready, 1);
    @(negedge CLK);
    in_valid = 1'b0;
    check("bp_next_valid", out_valid, 1);
    check("bp_next_data", out_data, 16'h0099);
    @(negedge CLK);

    // Reset mid-group, with an accept presented in the reset cycle.
    len = 8'd4;
    beat(16'h0100);
    beat(16'h0200);
    RST = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h0300;
    #1;
    check("midrst_in_ready", in_ready, 0);
    @(negedge CLK);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_ovf", out_ovf, 0);
    RST = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_idle_ready", in_ready, 1);
    @(negedge CLK);
    q = '{16'h0003, 16'h0004};
    run_group(8'd2, q, 0);
    result("after_rst", 16'h0007, 1'b0, 1'b0);

    // Maximum group length: counter must not wrap.
    q.delete();
    for (int i = 0; i < 255; i++) q.push_back(16'($urandom));
    model(q, ed, eo);
    run_group(8'd255, q, 0);
    result("len255", ed, eo, 1'b0);

    // Randomized groups with gaps and output backpressure.
    for (int g = 0; g < 40; g++) begin
      logic [7:0] l;
      int n;
      l = 8'($urandom_range(0, 12));
      n = (l == 0) ? 1 : int'(l);
      q.delete();
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 4))
          0: q.push_back(16'h7FFF);
          1: q.push_back(16'h8000);
          2: q.push_back(16'($urandom_range(0, 3)) - 16'd1);
          default: q.push_back(16'($urandom));
        endcase
      end
      model(q, ed, eo);
      run_group(l, q, 2);
      result($sformatf("rand%0d", g), ed, eo, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
